// File: rtl/word_alarm.sv
// Keyword alarm: confirms CONFIRM consecutive positive matcher frames, then beeps and holds off.
// Optional ALARM_VAD_GATE_EN: a positive frame only counts while vad_in is high.
module word_alarm #(
  parameter int unsigned CONFIRM        = 2,
  parameter int unsigned TONE_DIV       = 6250,
  parameter int unsigned BEEP_CYCLES    = 50000000,
  parameter int unsigned HOLDOFF_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       result_dv,
  input  logic       result,
  input  logic       vad_in,
  output logic       beep,
  output logic       led_detect,
  output logic       led_vad,
  output logic       alarm_pulse,
  output logic       busy,
  output logic [7:0] alarm_count
);

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_BEEP, S_HOLDOFF} state_t;

  state_t      state;
  logic [7:0]  streak;
  logic [31:0] cyc;
  logic [31:0] tone;
  logic        eff;
  logic        fire;

`ifdef ALARM_VAD_GATE_EN
  assign eff = result & vad_in;
`else
  assign eff = result;
`endif

  always_comb begin
    fire = 1'b0;
    if (result_dv && eff) begin
      case (state)
        S_IDLE:    fire = (CONFIRM == 32'd1);
        S_CONFIRM: fire = (({24'd0, streak} + 32'd1) == CONFIRM);
        default:   fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      streak      <= 8'd0;
      cyc         <= 32'd0;
      tone        <= 32'd0;
      beep        <= 1'b0;
      led_detect  <= 1'b0;
      led_vad     <= 1'b0;
      alarm_pulse <= 1'b0;
      busy        <= 1'b0;
      alarm_count <= 8'd0;
    end else begin
      alarm_pulse <= 1'b0;
      led_vad     <= vad_in;
      if (fire) begin
        state       <= S_BEEP;
        streak      <= 8'd0;
        cyc         <= 32'd0;
        tone        <= 32'd0;
        beep        <= 1'b0;
        led_detect  <= 1'b1;
        busy        <= 1'b1;
        alarm_pulse <= 1'b1;
        if (alarm_count != 8'hFF) alarm_count <= alarm_count + 8'd1;
      end else begin
        case (state)
          S_IDLE: begin
            if (result_dv) begin
              if (eff) begin
                streak <= 8'd1;
                state  <= S_CONFIRM;
              end else begin
                streak <= 8'd0;
              end
            end
          end
          S_CONFIRM: begin
            if (result_dv) begin
              if (eff) begin
                streak <= streak + 8'd1;
              end else begin
                streak <= 8'd0;
                state  <= S_IDLE;
              end
            end
          end
          S_BEEP: begin
            if (cyc == BEEP_CYCLES - 32'd1) begin
              cyc        <= 32'd0;
              tone       <= 32'd0;
              beep       <= 1'b0;
              led_detect <= 1'b0;
              if (HOLDOFF_CYCLES == 32'd0) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_HOLDOFF;
              end
            end else begin
              cyc <= cyc + 32'd1;
              // Tone wraps on TONE_DIV-1, giving a half-period of TONE_DIV cycles.
              if (tone == TONE_DIV - 32'd1) begin
                tone <= 32'd0;
                beep <= ~beep;
              end else begin
                tone <= tone + 32'd1;
              end
            end
          end
          S_HOLDOFF: begin
            if (cyc == HOLDOFF_CYCLES - 32'd1) begin
              cyc   <= 32'd0;
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              cyc <= cyc + 32'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_word_alarm.sv
// Randomized bench for word_alarm: timeline reference model plus alarm-pulse scoreboard.
module tb_word_alarm;
  localparam int CONFIRM = 2;
  localparam int TD      = 4;
  localparam int BC      = 32;
  localparam int HC      = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       result_dv;
  logic       result;
  logic       vad_in;
  logic       beep;
  logic       led_detect;
  logic       led_vad;
  logic       alarm_pulse;
  logic       busy;
  logic [7:0] alarm_count;

  always #5 clk = ~clk;

  word_alarm #(
    .CONFIRM(CONFIRM), .TONE_DIV(TD), .BEEP_CYCLES(BC), .HOLDOFF_CYCLES(HC)
  ) dut (
    .clk(clk), .reset(reset), .result_dv(result_dv), .result(result), .vad_in(vad_in),
    .beep(beep), .led_detect(led_detect), .led_vad(led_vad), .alarm_pulse(alarm_pulse),
    .busy(busy), .alarm_count(alarm_count)
  );

  typedef struct { int e_n; int cnt; } ev_t;
  ev_t  q[$];

  int   n = 0;
  int   fire_edge = -1000;
  int   streak = 0;
  int   count = 0;
  logic exp_vad = 1'b0;
  logic rst_req = 1'b1;
  bit   in_reset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, exp);
  endtask

  // Reference: the block is deaf for BC+HC edges after a fire; otherwise count positive strobes.
  task automatic model(input logic dv, input logic res, input logic vd);
    logic e;
    exp_vad = vd;
`ifdef ALARM_VAD_GATE_EN
    e = res & vd;
`else
    e = res;
`endif
    if (dv && n > fire_edge + BC + HC) begin
      if (e) begin
        streak++;
        if (streak == CONFIRM) begin
          streak    = 0;
          fire_edge = n;
          if (count < 255) count++;
          q.push_back('{n, count});
        end
      end else begin
        streak = 0;
      end
    end
  endtask

  task automatic cycle(input logic dv, input logic res, input logic vd);
    @(negedge clk);
    reset     = rst_req;
    in_reset  = rst_req;
    result_dv = dv;
    result    = res;
    vad_in    = vd;
    @(posedge clk);
    n++;
    if (!in_reset) model(dv, res, vd);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic model_reset();
    fire_edge = -1000;
    streak    = 0;
    count     = 0;
    exp_vad   = 1'b0;
    q.delete();
  endtask

  // Monitor: per-cycle output timeline and alarm-pulse scoreboard.
  always @(posedge clk) begin
    #1;
    if (!in_reset) begin
      int j;
      logic el, eb, ebp;
      ev_t ev;
      j   = n - fire_edge;
      el  = (j >= 0) && (j < BC);
      eb  = (j >= 0) && (j < BC + HC);
      ebp = el && (((j / TD) % 2) == 1);
      chk("outputs", {beep, led_detect, busy, led_vad, alarm_count},
          {ebp, el, eb, exp_vad, 8'(count)});
      if (alarm_pulse) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL pulse_unexpected at edge %0d: got pulse, expected none", n);
        end else begin
          ev = q.pop_front();
          chk("pulse_edge", n, ev.e_n);
          chk("pulse_count", alarm_count, ev.cnt);
        end
      end
      if (q.size() > 0 && q[0].e_n < n) begin
        checks++;
        $display("FAIL pulse_missing at edge %0d: got none, expected pulse at edge %0d", n, q[0].e_n);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; result_dv = 1'b0; result = 1'b0; vad_in = 1'b0;
    #1;
    chk("reset_state", {beep, led_detect, busy, led_vad, alarm_pulse, alarm_count}, 13'd0);
    rst_req = 1'b1;
    cycle(0, 0, 0); cycle(0, 0, 0);
    rst_req = 1'b0;
    model_reset();
    idle(4);

    // Basic alarm: two positives ten cycles apart.
    cycle(1, 1, 1); idle(9); cycle(1, 1, 1);
    idle(60);

    // Broken streak 1,0,1 then 1 fires.
    cycle(1, 1, 1); idle(2); cycle(1, 0, 1); idle(2); cycle(1, 1, 1); idle(2); cycle(1, 1, 1);
    idle(60);

    // Strobes during BEEP/HOLDOFF and on the exit edge are ignored.
    cycle(1, 1, 1); cycle(1, 1, 1);
    for (int i = 1; i < BC + HC; i++) cycle(1'(i % 5 == 0), 1'b1, 1'b1);
    cycle(1, 1, 1);
    cycle(1, 1, 1); cycle(1, 1, 1);
    idle(60);

    // Reset mid-BEEP while the tone is high.
    cycle(1, 1, 1); cycle(1, 1, 1);
    idle(5);
    #3;
    reset = 1'b1; in_reset = 1'b1; rst_req = 1'b1;
    #1;
    chk("reset_async", {beep, led_detect, busy, led_vad, alarm_pulse, alarm_count}, 13'd0);
    cycle(0, 0, 0); cycle(0, 0, 0);
    model_reset();
    rst_req = 1'b0;
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom));
    idle(60);

    // Saturation: 256 alarms.
    for (int a = 0; a < 256; a++) begin
      cycle(1, 1, 1); cycle(1, 1, 1);
      idle(BC + HC);
    end
    chk("saturated", alarm_count, 255);

    // VAD gating: positives with vad_in low.
    cycle(1, 1, 0); cycle(1, 1, 0);
    idle(60);

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
